// File: rtl/vx_dcache_sequencer.sv
// Serialises a multi-lane dcache batch onto a single memory port and gathers
// the (possibly out-of-order) read responses into one core response.
module vx_dcache_sequencer #(
  parameter int NUM_REQS  = 4,
  parameter int TAG_WIDTH = 8,
  parameter int LANE_BITS = $clog2(NUM_REQS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       core_req_valid,
  input  logic [NUM_REQS-1:0]       core_req_rw,
  input  logic [NUM_REQS-1:0][3:0]  core_req_byteen,
  input  logic [NUM_REQS-1:0][29:0] core_req_addr,
  input  logic [NUM_REQS-1:0][31:0] core_req_data,
  input  logic [TAG_WIDTH-1:0]      core_req_tag,
  output logic                      core_req_ready,
  output logic [NUM_REQS-1:0]       core_rsp_valid,
  output logic [NUM_REQS-1:0][31:0] core_rsp_data,
  output logic [TAG_WIDTH-1:0]      core_rsp_tag,
  input  logic                      core_rsp_ready,
  output logic                      mem_req_valid,
  output logic                      mem_req_rw,
  output logic [3:0]                mem_req_byteen,
  output logic [29:0]               mem_req_addr,
  output logic [31:0]               mem_req_data,
  output logic [LANE_BITS-1:0]      mem_req_tag,
  input  logic                      mem_req_ready,
  input  logic                      mem_rsp_valid,
  input  logic [31:0]               mem_rsp_data,
  input  logic [LANE_BITS-1:0]      mem_rsp_tag,
  output logic                      mem_rsp_ready,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RSP} state_t;

  state_t                      state_q;
  logic [NUM_REQS-1:0]         valid_q, rw_q, pending_q, rd_out_q;
  logic [NUM_REQS-1:0][3:0]    byteen_q;
  logic [NUM_REQS-1:0][29:0]   addr_q;
  logic [NUM_REQS-1:0][31:0]   wdata_q, rdata_q;
  logic [TAG_WIDTH-1:0]        tag_q;
  logic [LANE_BITS:0]          cnt_q;

  logic [LANE_BITS-1:0]        lane;
  logic [NUM_REQS-1:0]         lane_oh, pending_d, rd_out_d;
  logic [LANE_BITS:0]          cnt_d;
  logic                        accept, issue_fire, issue_rd, rsp_fire;

  // Lowest-indexed pending lane is the one presented to memory.
  always_comb begin
    lane = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--)
      if (pending_q[i]) lane = LANE_BITS'(i);
  end

  assign lane_oh    = NUM_REQS'(1) << lane;
  assign accept     = (state_q == IDLE) && (|core_req_valid);
  assign issue_fire = (state_q == ISSUE) && mem_req_ready;
  assign issue_rd   = issue_fire && !rw_q[lane];
  // Responses for lanes without an outstanding read are dropped.
  assign rsp_fire   = mem_rsp_valid && mem_rsp_ready && rd_out_q[mem_rsp_tag];

  assign pending_d = issue_fire ? (pending_q & ~lane_oh) : pending_q;
  assign cnt_d     = cnt_q + (LANE_BITS+1)'(issue_rd) - (LANE_BITS+1)'(rsp_fire);

  always_comb begin
    rd_out_d = rd_out_q;
    if (rsp_fire) rd_out_d[mem_rsp_tag] = 1'b0;
    if (issue_rd) rd_out_d = rd_out_d | lane_oh;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      rw_q      <= '0;
      pending_q <= '0;
      rd_out_q  <= '0;
      byteen_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      tag_q     <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      rd_out_q  <= rd_out_d;
      cnt_q     <= cnt_d;
      if (rsp_fire) rdata_q[mem_rsp_tag] <= mem_rsp_data;
      case (state_q)
        IDLE: if (accept) begin
          valid_q   <= core_req_valid;
          rw_q      <= core_req_rw;
          byteen_q  <= core_req_byteen;
          addr_q    <= core_req_addr;
          wdata_q   <= core_req_data;
          tag_q     <= core_req_tag;
          pending_q <= core_req_valid;
          rdata_q   <= '0;
          state_q   <= ISSUE;
        end
        ISSUE: if (issue_fire && pending_d == '0) begin
          if (cnt_d != '0)             state_q <= WAIT;
          else if (|(valid_q & ~rw_q)) state_q <= RSP;
          else                         state_q <= IDLE;
        end
        WAIT: if (cnt_d == '0) state_q <= RSP;
        RSP:  if (core_rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign core_req_ready = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign mem_req_valid  = (state_q == ISSUE);
  assign mem_req_rw     = rw_q[lane];
  assign mem_req_byteen = byteen_q[lane];
  assign mem_req_addr   = addr_q[lane];
  assign mem_req_data   = wdata_q[lane];
  assign mem_req_tag    = lane;
  assign mem_rsp_ready  = (state_q == ISSUE) || (state_q == WAIT);
  assign core_rsp_valid = (state_q == RSP) ? (valid_q & ~rw_q) : '0;
  assign core_rsp_data  = (state_q == RSP) ? rdata_q : '0;
  assign core_rsp_tag   = (state_q == RSP) ? tag_q : '0;

`ifndef SYNTHESIS
  stray_rsp_a: assert property (@(posedge clk) disable iff (reset)
    (mem_rsp_valid && mem_rsp_ready) |-> rd_out_q[mem_rsp_tag]);
`endif

endmodule

// File: tb/tb_vx_dcache_sequencer.sv
// Bench for vx_dcache_sequencer: directed scenarios plus randomized traffic
// compared every cycle against a batch-level reference model.
module tb_vx_dcache_sequencer;
  localparam int N  = 4;
  localparam int TW = 8;
  localparam int LB = 2;

  logic               clk = 0;
  logic               reset;
  logic [N-1:0]       core_req_valid, core_req_rw;
  logic [N-1:0][3:0]  core_req_byteen;
  logic [N-1:0][29:0] core_req_addr;
  logic [N-1:0][31:0] core_req_data;
  logic [TW-1:0]      core_req_tag;
  logic               core_req_ready;
  logic [N-1:0]       core_rsp_valid;
  logic [N-1:0][31:0] core_rsp_data;
  logic [TW-1:0]      core_rsp_tag;
  logic               core_rsp_ready;
  logic               mem_req_valid, mem_req_rw;
  logic [3:0]         mem_req_byteen;
  logic [29:0]        mem_req_addr;
  logic [31:0]        mem_req_data;
  logic [LB-1:0]      mem_req_tag;
  logic               mem_req_ready;
  logic               mem_rsp_valid;
  logic [31:0]        mem_rsp_data;
  logic [LB-1:0]      mem_rsp_tag;
  logic               mem_rsp_ready;
  logic               busy;

  vx_dcache_sequencer #(.NUM_REQS(N), .TAG_WIDTH(TW), .LANE_BITS(LB)) dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_rw(core_req_rw),
    .core_req_byteen(core_req_byteen), .core_req_addr(core_req_addr),
    .core_req_data(core_req_data), .core_req_tag(core_req_tag),
    .core_req_ready(core_req_ready),
    .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
    .core_rsp_tag(core_rsp_tag), .core_rsp_ready(core_rsp_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one batch in flight, described as lane lists and sets.
  bit                 m_active, m_rsp;
  int                 m_issue_q[$];
  logic [N-1:0]       m_await, m_valid, m_rw;
  logic [N-1:0][3:0]  m_be;
  logic [N-1:0][29:0] m_addr;
  logic [N-1:0][31:0] m_wdata, m_rdata;
  logic [TW-1:0]      m_tag;

  // Logs and responder plumbing
  int                 issue_log[$], issue_cyc[$];
  int                 rsp_q[$], force_q[$];
  int                 rsp_mode = 1;
  bit                 stray_en = 0;
  int                 rsp_cycles;
  logic [N-1:0]       last_rsp_valid;
  logic [N-1:0][31:0] last_rsp_data;
  logic [TW-1:0]      last_rsp_tag;

  task automatic model_clear();
    m_active = 0; m_rsp = 0; m_issue_q.delete();
    m_await = '0; m_valid = '0; m_rw = '0; m_rdata = '0;
  endtask

  always @(negedge clk) begin
    logic [N-1:0] rdmask;
    int l;
    cyc++;
    if (reset) model_clear();
    rdmask = m_valid & ~m_rw;
    chk("busy", 64'(busy), 64'(m_active));
    chk("core_req_ready", 64'(core_req_ready), 64'(!m_active));
    chk("mem_req_valid", 64'(mem_req_valid), 64'(m_active && !m_rsp && m_issue_q.size() > 0));
    chk("mem_rsp_ready", 64'(mem_rsp_ready), 64'(m_active && !m_rsp));
    chk("core_rsp_valid", 64'(core_rsp_valid), 64'(m_rsp ? rdmask : '0));
    if (m_active && !m_rsp && m_issue_q.size() > 0) begin
      l = m_issue_q[0];
      chk("mem_req_tag", 64'(mem_req_tag), 64'(l));
      chk("mem_req_rw", 64'(mem_req_rw), 64'(m_rw[l]));
      chk("mem_req_byteen", 64'(mem_req_byteen), 64'(m_be[l]));
      chk("mem_req_addr", 64'(mem_req_addr), 64'(m_addr[l]));
      chk("mem_req_data", 64'(mem_req_data), 64'(m_wdata[l]));
    end
    if (m_rsp) begin
      chk("core_rsp_tag", 64'(core_rsp_tag), 64'(m_tag));
      for (int i = 0; i < N; i++)
        chk($sformatf("core_rsp_data[%0d]", i), 64'(core_rsp_data[i]),
            64'(rdmask[i] ? m_rdata[i] : 32'h0));
    end
    if (reset) begin
      chk("rst_mem_req_addr", 64'(mem_req_addr), 64'h0);
      chk("rst_mem_req_data", 64'(mem_req_data), 64'h0);
      chk("rst_mem_req_tag", 64'(mem_req_tag), 64'h0);
      chk("rst_core_rsp_tag", 64'(core_rsp_tag), 64'h0);
      chk("rst_core_rsp_data", 64'(core_rsp_data), 64'h0);
    end
    if (core_rsp_valid != '0) begin
      rsp_cycles++;
      last_rsp_valid = core_rsp_valid;
      last_rsp_data  = core_rsp_data;
      last_rsp_tag   = core_rsp_tag;
    end
    // Advance the model by what the coming clock edge will do.
    if (!reset) begin
      if (!m_active) begin
        if (|core_req_valid) begin
          m_active = 1; m_valid = core_req_valid; m_rw = core_req_rw;
          m_be = core_req_byteen; m_addr = core_req_addr; m_wdata = core_req_data;
          m_tag = core_req_tag; m_rdata = '0; m_await = '0;
          for (int i = 0; i < N; i++) if (core_req_valid[i]) m_issue_q.push_back(i);
        end
      end else if (!m_rsp) begin
        l = -1;
        if (m_issue_q.size() > 0 && mem_req_ready) begin
          l = m_issue_q.pop_front();
          issue_log.push_back(l);
          issue_cyc.push_back(cyc);
        end
        if (mem_rsp_valid && m_await[mem_rsp_tag]) begin
          m_await[mem_rsp_tag] = 1'b0;
          m_rdata[mem_rsp_tag] = mem_rsp_data;
        end
        if (l >= 0 && !m_rw[l]) begin
          m_await[l] = 1'b1;
          rsp_q.push_back(l);
        end
        if (m_issue_q.size() == 0 && m_await == '0) begin
          if ((m_valid & ~m_rw) != '0) m_rsp = 1;
          else m_active = 0;
        end
      end else if (core_rsp_ready) begin
        m_active = 0; m_rsp = 0;
      end
    end
  end

  function automatic logic [31:0] lane_data(input int lane);
    return 32'hD000_0000 | 32'(lane);
  endfunction

  // Memory responder: 0 random order/gaps, 1 in order, 2 forced order, 3 hold.
  always @(posedge clk) begin
    int k, found;
    #1;
    mem_rsp_valid = 0; mem_rsp_tag = '0; mem_rsp_data = '0;
    if (stray_en) begin
      mem_rsp_valid = 1; mem_rsp_tag = LB'($urandom); mem_rsp_data = $urandom;
    end else begin
      case (rsp_mode)
        0: if (rsp_q.size() > 0 && $urandom_range(0, 2) != 0) begin
          k = $urandom_range(0, rsp_q.size() - 1);
          mem_rsp_valid = 1; mem_rsp_tag = LB'(rsp_q[k]); mem_rsp_data = $urandom;
          rsp_q.delete(k);
        end
        1: if (rsp_q.size() > 0) begin
          k = rsp_q.pop_front();
          mem_rsp_valid = 1; mem_rsp_tag = LB'(k); mem_rsp_data = lane_data(k);
        end
        2: if (force_q.size() > 0) begin
          found = -1;
          for (int j = 0; j < rsp_q.size(); j++) if (rsp_q[j] == force_q[0]) found = j;
          if (found >= 0) begin
            k = force_q.pop_front();
            mem_rsp_valid = 1; mem_rsp_tag = LB'(k); mem_rsp_data = lane_data(k);
            rsp_q.delete(found);
          end
        end
        default: ;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      core_req_byteen[i] = 4'($urandom);
      core_req_addr[i]   = 30'($urandom);
      core_req_data[i]   = $urandom;
    end
  endtask

  task automatic drive_batch(input logic [N-1:0] v, input logic [N-1:0] rw, input logic [TW-1:0] tag);
    tick();
    core_req_valid = v; core_req_rw = rw; core_req_tag = tag; rand_fields();
    tick();
    core_req_valid = '0;
  endtask

  task automatic clear_logs();
    issue_log.delete(); issue_cyc.delete();
    rsp_cycles = 0; last_rsp_valid = '0; last_rsp_data = '0; last_rsp_tag = '0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    @(negedge clk); #2;
    while (busy && k < 200) begin @(negedge clk); #2; k++; end
    chk(name, 64'(busy), 64'h0);
  endtask

  task automatic wait_issued(input int n, input string name);
    int k = 0;
    while (issue_log.size() < n && k < 100) begin @(negedge clk); #2; k++; end
    chk(name, 64'(issue_log.size()), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1; core_req_valid = '0; core_req_rw = '0; core_req_byteen = '0;
    core_req_addr = '0; core_req_data = '0; core_req_tag = '0;
    core_rsp_ready = 1; mem_req_ready = 1;
    clear_logs();
    repeat (3) @(negedge clk);
    #2;
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_mem_req_valid", 64'(mem_req_valid), 64'h0);
    chk("reset_core_rsp_valid", 64'(core_rsp_valid), 64'h0);
    tick(); reset = 0;
    @(negedge clk); #2;
    chk("post_reset_core_req_ready", 64'(core_req_ready), 64'h1);

    // Read batch 1011, in-order single-cycle responses
    rsp_mode = 1; clear_logs();
    drive_batch(4'b1011, 4'b0000, 8'h5A);
    wait_idle("t1_idle");
    chk("t1_n_issued", 64'(issue_log.size()), 64'd3);
    if (issue_log.size() == 3) begin
      chk("t1_tag0", 64'(issue_log[0]), 64'd0);
      chk("t1_tag1", 64'(issue_log[1]), 64'd1);
      chk("t1_tag2", 64'(issue_log[2]), 64'd3);
      chk("t1_gap01", 64'(issue_cyc[1] - issue_cyc[0]), 64'd1);
      chk("t1_gap12", 64'(issue_cyc[2] - issue_cyc[1]), 64'd1);
    end
    chk("t1_rsp_valid", 64'(last_rsp_valid), 64'hB);
    chk("t1_rsp_tag", 64'(last_rsp_tag), 64'h5A);
    chk("t1_data0", 64'(last_rsp_data[0]), 64'hD000_0000);
    chk("t1_data1", 64'(last_rsp_data[1]), 64'hD000_0001);
    chk("t1_data2", 64'(last_rsp_data[2]), 64'h0);
    chk("t1_data3", 64'(last_rsp_data[3]), 64'hD000_0003);

    // All-write batch
    clear_logs();
    drive_batch(4'b1111, 4'b1111, 8'h11);
    wait_issued(4, "t2_n_issued");
    chk("t2_busy_at_last_hs", 64'(busy), 64'h1);
    @(negedge clk); #2;
    chk("t2_busy_drop", 64'(busy), 64'h0);
    chk("t2_no_core_rsp", 64'(rsp_cycles), 64'd0);

    // Out-of-order responses 3,0,2,1
    rsp_mode = 2; force_q = '{3, 0, 2, 1}; clear_logs();
    drive_batch(4'b1111, 4'b0000, 8'hC3);
    wait_idle("t3_idle");
    chk("t3_rsp_valid", 64'(last_rsp_valid), 64'hF);
    chk("t3_rsp_tag", 64'(last_rsp_tag), 64'hC3);
    for (int i = 0; i < N; i++)
      chk($sformatf("t3_data%0d", i), 64'(last_rsp_data[i]), 64'(lane_data(i)));

    // Memory stall during ISSUE
    rsp_mode = 1; clear_logs(); mem_req_ready = 0;
    drive_batch(4'b1111, 4'b0101, 8'h33);
    tick(); tick();
    chk("t4_core_req_ready_stall", 64'(core_req_ready), 64'h0);
    chk("t4_mem_req_tag_stall", 64'(mem_req_tag), 64'h0);
    chk("t4_none_issued", 64'(issue_log.size()), 64'd0);
    tick(); mem_req_ready = 1;
    wait_idle("t4_idle");
    chk("t4_n_issued", 64'(issue_log.size()), 64'd4);
    for (int i = 0; i < issue_log.size(); i++)
      chk($sformatf("t4_tag%0d", i), 64'(issue_log[i]), 64'(i));

    // Core response back-pressure
    clear_logs(); core_rsp_ready = 0;
    drive_batch(4'b0110, 4'b0000, 8'h77);
    k = 0;
    do begin @(negedge clk); #2; k++; end while (core_rsp_valid == '0 && k < 100);
    chk("t5_rsp_valid", 64'(core_rsp_valid), 64'h6);
    repeat (5) begin tick(); core_req_valid = 4'b1111; rand_fields(); end
    @(negedge clk); #2;
    chk("t5_hold_busy", 64'(busy), 64'h1);
    chk("t5_hold_tag", 64'(core_rsp_tag), 64'h77);
    tick(); core_rsp_ready = 1; core_req_valid = '0;
    @(negedge clk); #2;
    chk("t5_ready_cycle_busy", 64'(busy), 64'h1);
    @(negedge clk); #2;
    chk("t5_idle_after", 64'(busy), 64'h0);

    // Reset in WAIT with two reads outstanding, then stray responses
    rsp_mode = 3; clear_logs();
    drive_batch(4'b0011, 4'b0000, 8'h42);
    wait_issued(2, "t6_n_issued");
    @(negedge clk); #2;
    chk("t6_wait_busy", 64'(busy), 64'h1);
    chk("t6_wait_rsp_ready", 64'(mem_rsp_ready), 64'h1);
    chk("t6_wait_no_req", 64'(mem_req_valid), 64'h0);
    tick(); reset = 1; rsp_q.delete();
    @(negedge clk); #2;
    chk("t6_rst_busy", 64'(busy), 64'h0);
    chk("t6_rst_core_rsp_valid", 64'(core_rsp_valid), 64'h0);
    tick(); reset = 0; stray_en = 1;
    repeat (4) tick();
    stray_en = 0;
    @(negedge clk); #2;
    chk("t6_stray_busy", 64'(busy), 64'h0);
    chk("t6_stray_no_rsp", 64'(rsp_cycles), 64'd0);
    rsp_mode = 1; clear_logs();
    drive_batch(4'b0001, 4'b0000, 8'h99);
    wait_idle("t6_after_idle");
    chk("t6_after_valid", 64'(last_rsp_valid), 64'h1);
    chk("t6_after_data", 64'(last_rsp_data[0]), 64'hD000_0000);

    // Randomized traffic with stalls, out-of-order responses and resets
    rsp_mode = 0;
    repeat (600) begin
      tick();
      reset = ($urandom_range(0, 99) == 0);
      if (reset) rsp_q.delete();
      core_req_valid = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      core_req_rw = N'($urandom); core_req_tag = TW'($urandom); rand_fields();
      mem_req_ready = ($urandom_range(0, 3) != 0);
      core_rsp_ready = ($urandom_range(0, 2) != 0);
    end
    tick();
    reset = 0; core_req_valid = '0; mem_req_ready = 1; core_rsp_ready = 1;
    wait_idle("drain_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
